// File: rtl/execution_stage_pkg.sv
// Shared decode constants for the RV32I execute stage.
package execution_stage_pkg;

    // Register/immediate ALU funct3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Conditional branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // M-extension funct3 encodings (only meaningful with F7_MULDIV)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // funct7 encodings
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I ALU and branch comparator.
// With EXEC_MUL_EN defined, funct7 0000001 on register ops selects MUL/MULH/MULHSU/MULHU
// and yields 0 for the divide encodings.
module exec_alu
    import execution_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic            is_imm_i,
    input  logic            is_branch_i,
    output logic [XLEN-1:0] result_o,
    output logic            taken_o
);

    logic [XLEN-1:0] diff;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;

    assign diff  = a_i - b_i;
    assign shamt = b_i[4:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

`ifdef EXEC_MUL_EN
    logic [2*XLEN-1:0] prod_ss;
    logic [2*XLEN-1:0] prod_su;
    logic [2*XLEN-1:0] prod_uu;

    // Operands are extended to double width, so the low 2*XLEN bits are the exact product
    assign prod_ss = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{b_i[XLEN-1]}}, b_i};
    assign prod_su = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{1'b0}}, b_i};
    assign prod_uu = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};
`endif

    // Select the result and branch decision from funct3/funct7
    always_comb begin
        result_o = '0;
        taken_o  = 1'b0;
        if (is_branch_i) begin
            result_o = diff;
            case (funct3_i)
                F3_BEQ:  taken_o = (a_i == b_i);
                F3_BNE:  taken_o = (a_i != b_i);
                F3_BLT:  taken_o = lt_s;
                F3_BGE:  taken_o = !lt_s;
                F3_BLTU: taken_o = lt_u;
                F3_BGEU: taken_o = !lt_u;
                default: taken_o = 1'b0;
            endcase
`ifdef EXEC_MUL_EN
        end else if (!is_imm_i && funct7_i == F7_MULDIV) begin
            case (funct3_i)
                F3_MUL:    result_o = prod_uu[XLEN-1:0];
                F3_MULH:   result_o = prod_ss[2*XLEN-1:XLEN];
                F3_MULHSU: result_o = prod_su[2*XLEN-1:XLEN];
                F3_MULHU:  result_o = prod_uu[2*XLEN-1:XLEN];
                default:   result_o = '0;
            endcase
`endif
        end else begin
            case (funct3_i)
                // Immediate forms have no SUB; funct7 bits there belong to the immediate
                F3_ADD:  result_o = (!is_imm_i && funct7_i == F7_ALT) ? diff : a_i + b_i;
                F3_SLL:  result_o = a_i << shamt;
                F3_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
                F3_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
                F3_XOR:  result_o = a_i ^ b_i;
                F3_SR:   result_o = funct7_i[5] ? $unsigned($signed(a_i) >>> shamt)
                                                : a_i >> shamt;
                F3_OR:   result_o = a_i | b_i;
                F3_AND:  result_o = a_i & b_i;
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/execution_stage.sv
// RV32I execute stage: operand select, ALU, branch target adder, registered outputs.
// Optional macro EXEC_MUL_EN enables the multiply subset in exec_alu.
module execution_stage
    import execution_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic [2*XLEN-1:0] sign_extended,
    input  logic [2:0]        ALU_op,
    input  logic [6:0]        ALU_op_ext,
    input  logic              ALU_src,
    input  logic [XLEN-1:0]   imm_value,
    input  logic [XLEN-1:0]   in_pc_value,
    input  logic              is_branch_in,
    output logic [XLEN-1:0]   res,
    output logic              zero,
    output logic [XLEN-1:0]   branch_result,
    output logic [XLEN-1:0]   second_reg_propagation,
    output logic              is_branch_out
);

    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_taken;
    logic [XLEN-1:0] branch_target;
    logic            unused_se_hi;

    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [XLEN-1:0] branch_result_q;
    logic [XLEN-1:0] store_data_q;
    logic            taken_q;

    // Branches always compare rs1 against rs2, whatever ALU_src says
    assign operand_b     = (ALU_src && !is_branch_in) ? imm_value : op2;
    assign branch_target = in_pc_value + sign_extended[XLEN-1:0];
    assign unused_se_hi  = ^sign_extended[2*XLEN-1:XLEN];

    exec_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a_i         (op1),
        .b_i         (operand_b),
        .funct3_i    (ALU_op),
        .funct7_i    (ALU_op_ext),
        .is_imm_i    (ALU_src),
        .is_branch_i (is_branch_in),
        .result_o    (alu_result),
        .taken_o     (alu_taken)
    );

    // Capture this cycle's results; reset discards anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q           <= '0;
            zero_q          <= 1'b0;
            branch_result_q <= '0;
            store_data_q    <= '0;
            taken_q         <= 1'b0;
        end else begin
            res_q           <= alu_result;
            zero_q          <= (alu_result == '0);
            branch_result_q <= branch_target;
            store_data_q    <= op2;
            taken_q         <= is_branch_in && alu_taken;
        end
    end

    assign res                    = res_q;
    assign zero                   = zero_q;
    assign branch_result          = branch_result_q;
    assign second_reg_propagation = store_data_q;
    assign is_branch_out          = taken_q;

endmodule

// File: tb/tb_execution_stage.sv
// Self-checking bench for execution_stage: directed plan cases plus random ops
// compared against an arithmetic reference model.
module tb_execution_stage;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] sign_extended;
    logic [2:0]  ALU_op;
    logic [6:0]  ALU_op_ext;
    logic        ALU_src;
    logic [31:0] imm_value;
    logic [31:0] in_pc_value;
    logic        is_branch_in;
    logic [31:0] res;
    logic        zero;
    logic [31:0] branch_result;
    logic [31:0] second_reg_propagation;
    logic        is_branch_out;

    int n_checks;
    int n_fail;

    execution_stage #(
        .XLEN (32)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .op1                    (op1),
        .op2                    (op2),
        .sign_extended          (sign_extended),
        .ALU_op                 (ALU_op),
        .ALU_op_ext             (ALU_op_ext),
        .ALU_src                (ALU_src),
        .imm_value              (imm_value),
        .in_pc_value            (in_pc_value),
        .is_branch_in           (is_branch_in),
        .res                    (res),
        .zero                   (zero),
        .branch_result          (branch_result),
        .second_reg_propagation (second_reg_propagation),
        .is_branch_out          (is_branch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I semantics from plain integer arithmetic on the current inputs
    function automatic void model(output logic [31:0] r, output logic t);
        logic [31:0]       b;
        longint            sa;
        longint            sb;
        longint            ua;
        longint            ub;
        longint unsigned   pu;
        int                sh;
        b  = ALU_src ? imm_value : op2;
        if (is_branch_in) b = op2;
        sa = longint'($signed(op1));
        sb = longint'($signed(b));
        ua = longint'(op1);
        ub = longint'(b);
        sh = int'(b % 32);
        r  = 32'd0;
        t  = 1'b0;
        if (is_branch_in) begin
            r = 32'(ua - ub);
            case (ALU_op)
                3'd0: t = (ua == ub);
                3'd1: t = (ua != ub);
                3'd4: t = (sa < sb);
                3'd5: t = (sa >= sb);
                3'd6: t = (ua < ub);
                3'd7: t = (ua >= ub);
                default: t = 1'b0;
            endcase
            return;
        end
`ifdef EXEC_MUL_EN
        if (!ALU_src && ALU_op_ext == 7'd1) begin
            pu = longint unsigned'(ua) * longint unsigned'(ub);
            case (ALU_op)
                3'd0: r = 32'(pu);
                3'd1: r = 32'((sa * sb) >>> 32);
                3'd2: r = 32'((sa * ub) >>> 32);
                3'd3: r = 32'(pu >> 32);
                default: r = 32'd0;
            endcase
            return;
        end
`endif
        pu = 0;
        case (ALU_op)
            3'd0: r = (!ALU_src && ALU_op_ext == 7'h20) ? 32'(ua - ub) : 32'(ua + ub);
            3'd1: r = 32'(ua << sh);
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = op1 ^ b;
            3'd5: r = ALU_op_ext[5] ? 32'(sa >>> sh) : 32'(ua >> sh);
            3'd6: r = op1 | b;
            default: r = op1 & b;
        endcase
        if (pu != 0) r = 32'd0;
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] er;
        logic        et;
        model(er, et);
        chk({tag, ".res"}, res, er);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        chk({tag, ".taken"}, {31'd0, is_branch_out}, {31'd0, et});
        chk({tag, ".target"}, branch_result, in_pc_value + sign_extended[31:0]);
        chk({tag, ".store"}, second_reg_propagation, op2);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic [6:0] f7, input logic src, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [63:0] se, input logic br);
        op1           = a;
        op2           = b;
        ALU_op        = f3;
        ALU_op_ext    = f7;
        ALU_src       = src;
        imm_value     = imm;
        in_pc_value   = pc;
        sign_extended = se;
        is_branch_in  = br;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        op1           = $urandom;
        op2           = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom;
        sign_extended = {$urandom, $urandom};
        ALU_op        = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: ALU_op_ext = 7'h00;
            1: ALU_op_ext = 7'h20;
            2: ALU_op_ext = 7'h01;
            default: ALU_op_ext = 7'($urandom);
        endcase
        ALU_src       = 1'($urandom_range(0, 1));
        imm_value     = $urandom;
        in_pc_value   = $urandom;
        is_branch_in  = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) op1 = op2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        randomize_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.res", res, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd0);
        chk("rst.target", branch_result, 32'd0);
        chk("rst.store", second_reg_propagation, 32'd0);
        chk("rst.taken", {31'd0, is_branch_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_model("post_rst");

        drive(32'd5, 32'd3, 3'b000, 7'h20, 1'b0, 32'd0, 32'd0, 64'd0, 1'b0);
        chk("sub.res", res, 32'd2);
        chk("sub.zero", {31'd0, zero}, 32'd0);
        drive(32'd5, 32'd3, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 64'd0, 1'b0);
        chk("add.res", res, 32'd8);
        drive(32'hFFFF_FFFF, 32'd1, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 64'd0, 1'b0);
        chk("add_wrap.res", res, 32'd0);
        chk("add_wrap.zero", {31'd0, zero}, 32'd1);
        drive(32'h8000_0000, 32'd0, 3'b101, 7'h20, 1'b1, 32'd4, 32'd0, 64'd0, 1'b0);
        chk("srai.res", res, 32'hF800_0000);
        drive(32'h8000_0000, 32'd0, 3'b101, 7'h00, 1'b1, 32'd4, 32'd0, 64'd0, 1'b0);
        chk("srli.res", res, 32'h0800_0000);
        drive(32'hFFFF_FFFF, 32'd1, 3'b010, 7'h00, 1'b0, 32'd0, 32'd0, 64'd0, 1'b0);
        chk("slt.res", res, 32'd1);
        drive(32'hFFFF_FFFF, 32'd1, 3'b011, 7'h00, 1'b0, 32'd0, 32'd0, 64'd0, 1'b0);
        chk("sltu.res", res, 32'd0);
        drive(32'd7, 32'd7, 3'b000, 7'h00, 1'b0, 32'd0, 32'h100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        chk("beq.taken", {31'd0, is_branch_out}, 32'd1);
        chk("beq.target", branch_result, 32'h0000_00F8);
        chk("beq.zero", {31'd0, zero}, 32'd1);
        drive(32'd7, 32'd7, 3'b001, 7'h00, 1'b0, 32'd0, 32'h100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        chk("bne.taken", {31'd0, is_branch_out}, 32'd0);
        drive(32'd1, 32'hFFFF_FFFF, 3'b110, 7'h00, 1'b1, 32'd1, 32'h0, 64'd0, 1'b1);
        chk("bltu.taken", {31'd0, is_branch_out}, 32'd1);
        drive(32'd1, 32'd2, 3'b010, 7'h00, 1'b0, 32'd0, 32'h0, 64'd0, 1'b1);
        chk("b010.taken", {31'd0, is_branch_out}, 32'd0);
        drive(32'h1000, 32'hDEAD_BEEF, 3'b000, 7'h00, 1'b1, 32'h10, 32'h0, 64'd0, 1'b0);
        chk("store.fwd", second_reg_propagation, 32'hDEAD_BEEF);
        chk("store.res", res, 32'h1010);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 7'h01, 1'b0, 32'd0, 32'h0, 64'd0, 1'b0);
`ifdef EXEC_MUL_EN
        chk("mul.res", res, 32'd1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 7'h01, 1'b0, 32'd0, 32'h0, 64'd0, 1'b0);
        chk("mulhu.res", res, 32'hFFFF_FFFE);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 7'h01, 1'b0, 32'd0, 32'h0, 64'd0, 1'b0);
        chk("mulh.res", res, 32'd0);
        drive(32'd9, 32'd3, 3'b100, 7'h01, 1'b0, 32'd0, 32'h0, 64'd0, 1'b0);
        chk("div.res", res, 32'd0);
`else
        chk("f7_01_add.res", res, 32'hFFFF_FFFE);
`endif

        // Reset mid-operation clears outputs immediately, then capture resumes
        drive(32'd40, 32'd2, 3'b000, 7'h00, 1'b0, 32'd0, 32'h200, 64'd4, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst.res", res, 32'd0);
        chk("mid_rst.target", branch_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_model("after_mid_rst");

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            @(posedge clk);
            #1;
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
